// File: rtl/pipe_mux_nx1.sv
// Registered N:1 select stage with valid/ready handshakes, a 2-entry skid buffer, flush and sel_err.
// Optional macro PIPE_MUX_PARITY_EN adds out_parity, the even parity of out_data, stored per entry.
module pipe_mux_nx1 #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = ($clog2(NUM_IN) > 0) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    sel_err
`ifdef PIPE_MUX_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             sel_err_q, sel_err_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  logic             accept, emit;

  // Out-of-range selects leave sel_data at zero and sel_hit low.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign sel_err   = sel_err_q;
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = sel_data;
          end
        end
        StOne: begin
          if (accept && !emit) begin
            state_d = StFull;
            skid_d  = sel_data;
          end else if (accept && emit) begin
            main_d = sel_data;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (emit) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign in_ready_d = (state_d != StFull);

  // A set from an erroneous accept wins over a simultaneous clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && !flush && !sel_hit) begin
      sel_err_d = 1'b1;
    end else if (clr_err) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

`ifdef PIPE_MUX_PARITY_EN
  logic main_par_q, main_par_d;
  logic skid_par_q, skid_par_d;

  // Parity bits travel with their entries along the same paths as the data.
  always_comb begin
    main_par_d = main_par_q;
    skid_par_d = skid_par_q;
    if (flush) begin
      main_par_d = 1'b0;
      skid_par_d = 1'b0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) main_par_d = ^sel_data;
        end
        StOne: begin
          if (accept && !emit) begin
            skid_par_d = ^sel_data;
          end else if (accept && emit) begin
            main_par_d = ^sel_data;
          end
        end
        StFull: begin
          if (emit) begin
            main_par_d = skid_par_q;
            skid_par_d = 1'b0;
          end
        end
        default: main_par_d = main_par_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      main_par_q <= main_par_d;
      skid_par_q <= skid_par_d;
    end
  end

  assign out_parity = main_par_q;
`endif

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Randomised self-checking bench for pipe_mux_nx1 (NUM_IN=3, WIDTH=5) against a queue-based model.
module tb_pipe_mux_nx1;
  localparam int unsigned W = 5;
  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [1:0]     sel;
  logic           in_valid, in_ready, out_valid, out_ready, flush, clr_err, sel_err;
  logic [W-1:0]   out_data;
`ifdef PIPE_MUX_PARITY_EN
  logic           out_parity;
`endif

  pipe_mux_nx1 #(.WIDTH(W), .NUM_IN(N)) dut (
`ifdef PIPE_MUX_PARITY_EN
    .out_parity (out_parity),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .clr_err   (clr_err),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  logic [W-1:0] mq[$];
  bit           m_err;

  function automatic logic [W-1:0] ref_sel(input logic [N*W-1:0] d, input logic [1:0] s);
    logic [N*W-1:0] sh;
    if (int'(s) >= int'(N)) return '0;
    sh = d >> (int'(s) * int'(W));
    return sh[W-1:0];
  endfunction

  // Advances one clock and updates the model from the inputs held across that edge.
  task automatic tick();
    bit           acc, emt, bad;
    logic [W-1:0] v;
    acc = in_valid && rst_n && (mq.size() < 2);
    emt = rst_n && out_ready && (mq.size() != 0);
    bad = int'(sel) >= int'(N);
    v   = ref_sel(in_data, sel);
    @(posedge clk);
    if (rst_n) begin
      if (flush) mq.delete();
      else begin
        if (emt) mq.delete(0);
        if (acc) mq.push_back(v);
      end
      if (acc && !flush && bad) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; clr_err = 0; sel = 0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_err = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
`ifdef PIPE_MUX_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
    rst_n = 1;
  endtask

  task automatic test_single();
    in_data = {5'd2, 5'd1, 5'd0}; sel = 2'd2; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd2) begin
      errors++; $display("FAIL single_out: got v=%b d=%0d want v=1 d=2", out_valid, out_data);
    end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL single_sel_err: got %b want 0", sel_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1;
    sel = 2'd0; in_data = {5'd0, 5'd0, 5'd7};
    tick();
    sel = 2'd1; in_data = {5'd0, 5'd9, 5'd0};
    tick();
    in_valid = 0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd7) begin
      errors++; $display("FAIL bp_hold: got v=%b d=%0d want v=1 d=7", out_valid, out_data);
    end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd9) begin
      errors++; $display("FAIL bp_second: got v=%b d=%0d want v=1 d=9", out_valid, out_data);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [N*W-1:0] d;
    logic [31:0]    r;
    int             seen;
    seen = 0;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      sel = 2'($urandom_range(0, 2));
      r = $urandom(); d = r[N*W-1:0];
      d[int'(sel)*int'(W) +: W] = W'(i + 1);
      in_data = d;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== W'(i + 1)) begin
        errors++; $display("FAIL stream_data[%0d]: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, i + 1);
      end else seen++;
    end
    in_valid = 0;
    tick();
    checks++; if (seen != 20 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_count: got %0d outputs v=%b want 20 v=0", seen, out_valid);
    end
  endtask

  task automatic test_bad_sel();
    out_ready = 1; in_valid = 1; sel = 2'd3; in_data = '1;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++; $display("FAIL badsel_data: got v=%b d=%0d want v=1 d=0", out_valid, out_data);
    end
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL badsel_set: got %b want 1", sel_err); end
    repeat (3) tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL badsel_sticky: got %b want 1", sel_err); end
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL badsel_clear: got %b want 0", sel_err); end
    clr_err = 1; in_valid = 1; sel = 2'd3;
    tick();
    clr_err = 0; in_valid = 0;
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL badsel_set_wins: got %b want 1", sel_err); end
    clr_err = 1;
    tick();
    clr_err = 0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; sel = 2'd1; in_data = {5'd4, 5'd11, 5'd6};
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull: got %b want 0", in_ready); end
    flush = 1; out_ready = 1; sel = 2'd3;
    tick();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_zero: got %0d want 0", out_data); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL flush_no_err: got %b want 0", sel_err); end
    out_ready = 0; in_valid = 1; sel = 2'd0; in_data = {5'd1, 5'd2, 5'd21};
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd21) begin
      errors++; $display("FAIL flush_next: got v=%b d=%0d want v=1 d=21", out_valid, out_data);
    end
    out_ready = 1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      r = $urandom(); in_data = r[N*W-1:0];
      flush     = ($urandom_range(0, 19) == 0);
      clr_err   = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if (out_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, mq.size() != 0);
      end
      checks++; if (in_ready !== (mq.size() < 2)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, mq.size() < 2);
      end
      checks++; if (sel_err !== m_err) begin
        errors++; $display("FAIL rand_sel_err[%0d]: got %b want %b", i, sel_err, m_err);
      end
      if (mq.size() != 0) begin
        checks++; if (out_data !== mq[0]) begin
          errors++; $display("FAIL rand_data[%0d]: got %0d want %0d", i, out_data, mq[0]);
        end
`ifdef PIPE_MUX_PARITY_EN
        checks++; if (out_parity !== ^mq[0]) begin
          errors++; $display("FAIL rand_parity[%0d]: got %b want %b", i, out_parity, ^mq[0]);
        end
`endif
      end
    end
    flush = 0; clr_err = 0; in_valid = 0; out_ready = 1;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1;
    sel = 2'd0; in_data = {5'd0, 5'd0, 5'b10110};
    tick();
    sel = 2'd3;
    tick();
    in_valid = 0;
    checks++; if (in_ready !== 1'b0 || sel_err !== 1'b1 || out_data !== 5'b10110) begin
      errors++; $display("FAIL arst_prefull: got r=%b e=%b d=%0d want r=0 e=1 d=22", in_ready, sel_err, out_data);
    end
`ifdef PIPE_MUX_PARITY_EN
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL arst_parity: got %b want 1", out_parity); end
`endif
    #3 rst_n = 0;
    #1;
    mq.delete(); m_err = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    checks++; if (out_data !== '0 || sel_err !== 1'b0) begin
      errors++; $display("FAIL arst_clear: got d=%0d e=%b want d=0 e=0", out_data, sel_err);
    end
`ifdef PIPE_MUX_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL arst_parity_clr: got %b want 0", out_parity); end
`endif
    #1 rst_n = 1;
    in_valid = 1; sel = 2'd1; in_data = {5'd0, 5'd13, 5'd0};
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 5'd13) begin
      errors++; $display("FAIL arst_first_accept: got v=%b d=%0d want v=1 d=13", out_valid, out_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_bad_sel();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
